// File: rtl/rsa_pkg.sv
// Shared constants and FSM state encoding for the RSA encoder/decoder blocks.
package rsa_pkg;

   localparam int RSA_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE,
      REDUCE,
      SQUARE,
      MULT,
      DONE
   } rsa_state_e;

endpackage

// File: rtl/rsa_modmul.sv
// Sequential (a*b) mod n: interleaved shift-add, MSB-first over b, one bit per cycle.
// The start cycle performs the first step, so a result is ready WIDTH cycles after start.
module rsa_modmul
   import rsa_pkg::*;
#(
   parameter int WIDTH = RSA_WIDTH
)
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] n_i,
   output logic [WIDTH-1:0] res_o,
   output logic             done_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] n_q, n_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Operands stay below n, so WIDTH+1 bits and one conditional subtract suffice.
   function automatic logic [WIDTH-1:0] mod_step(input logic [WIDTH-1:0] acc,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] n,
                                                 input logic             bit_i);
      logic [WIDTH:0] t;
      t = {acc, 1'b0};
      if (t >= {1'b0, n}) t = t - {1'b0, n};
      if (bit_i) begin
         t = t + {1'b0, a};
         if (t >= {1'b0, n}) t = t - {1'b0, n};
      end
      return t[WIDTH-1:0];
   endfunction

   always_comb begin
      acc_d  = acc_q;
      a_d    = a_q;
      n_d    = n_q;
      sh_d   = sh_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (start_i) begin
         acc_d  = mod_step('0, a_i, n_i, b_i[WIDTH-1]);
         sh_d   = b_i << 1;
         a_d    = a_i;
         n_d    = n_i;
         cnt_d  = CW'(1);
         busy_d = 1'b1;
      end else if (busy_q) begin
         acc_d = mod_step(acc_q, a_q, n_q, sh_q[WIDTH-1]);
         sh_d  = sh_q << 1;
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CW'(WIDTH-1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q  <= '0;
         a_q    <= '0;
         n_q    <= '0;
         sh_q   <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         a_q    <= a_d;
         n_q    <= n_d;
         sh_q   <= sh_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign res_o  = acc_q;
   assign done_o = done_q;

endmodule

// File: rtl/rsa_decoder.sv
// Constant-time RSA decode M = C^D mod N: left-to-right square-and-always-multiply
// over a single shared sequential modular multiplier.
module rsa_decoder
   import rsa_pkg::*;
#(
   parameter int WIDTH = RSA_WIDTH
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] C,
   input  logic [WIDTH-1:0] D,
   input  logic [WIDTH-1:0] N,
   output logic [WIDTH-1:0] M,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   rsa_state_e       state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] n_q, n_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic             err_q, err_d;

   logic             mm_start, mm_done;
   logic [WIDTH-1:0] mm_a, mm_b, mm_n, mm_res, r_new;

   rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
      .clk_i   (clk),
      .rst_ni  (rst),
      .start_i (mm_start),
      .a_i     (mm_a),
      .b_i     (mm_b),
      .n_i     (mm_n),
      .res_o   (mm_res),
      .done_o  (mm_done)
   );

   // Each multiply is launched in the cycle its predecessor reports done, so the
   // multiplier never idles and total latency is fixed.
   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      b_d      = b_q;
      d_d      = d_q;
      n_d      = n_q;
      m_d      = m_q;
      bit_d    = bit_q;
      err_d    = err_q;
      mm_start = 1'b0;
      mm_a     = r_q;
      mm_b     = r_q;
      mm_n     = n_q;
      r_new    = d_q[bit_q] ? mm_res : r_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               err_d = 1'b0;
               d_d   = D;
               n_d   = N;
               if (N < WIDTH'(2)) begin
                  err_d   = 1'b1;
                  m_d     = '0;
                  state_d = DONE;
               end else begin
                  mm_start = 1'b1;
                  mm_a     = WIDTH'(1);
                  mm_b     = C;
                  mm_n     = N;
                  state_d  = REDUCE;
               end
            end
         end
         REDUCE: begin
            if (mm_done) begin
               b_d      = mm_res;
               r_d      = WIDTH'(1);
               bit_d    = BW'(WIDTH-1);
               mm_start = 1'b1;
               mm_a     = WIDTH'(1);
               mm_b     = WIDTH'(1);
               state_d  = SQUARE;
            end
         end
         SQUARE: begin
            if (mm_done) begin
               r_d      = mm_res;
               mm_start = 1'b1;
               mm_a     = mm_res;
               mm_b     = b_q;
               state_d  = MULT;
            end
         end
         MULT: begin
            if (mm_done) begin
               r_d = r_new;
               if (bit_q == '0) begin
                  m_d     = r_new;
                  state_d = DONE;
               end else begin
                  bit_d    = bit_q - 1'b1;
                  mm_start = 1'b1;
                  mm_a     = r_new;
                  mm_b     = r_new;
                  state_d  = SQUARE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         r_q     <= '0;
         b_q     <= '0;
         d_q     <= '0;
         n_q     <= '0;
         m_q     <= '0;
         bit_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         b_q     <= b_d;
         d_q     <= d_d;
         n_q     <= n_d;
         m_q     <= m_d;
         bit_q   <= bit_d;
         err_q   <= err_d;
      end
   end

   assign M    = m_q;
   assign err  = err_q;
   assign done = (state_q == DONE);
   assign busy = (state_q == REDUCE) || (state_q == SQUARE) || (state_q == MULT);

endmodule

// File: tb/tb_rsa_decoder.sv
// Directed bench for rsa_decoder: known RSA vectors, error path, abort, ignored restart, back-to-back.
module tb_rsa_decoder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] C = '0;
   logic [W-1:0] D = '0;
   logic [W-1:0] N = '0;
   logic [W-1:0] M;
   logic         busy, done, err;

   int checks = 0;
   int failures = 0;

   rsa_decoder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .C     (C),
      .D     (D),
      .N     (N),
      .M     (M),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   always #5 clk = ~clk;

   // Called at a negedge; returns at a negedge. Inputs are scrambled after the
   // sampling edge to show the operands were latched.
   task automatic run_decode(input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] n,
                             input logic [W-1:0] em, input logic ee, input int elat,
                             input string name);
      int cyc = 0;
      int bcyc = 0;
      start = 1'b1; C = c; D = d; N = n;
      @(posedge clk);
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start = 1'b0; C = ~c; D = ~d; N = 8'd1;
         end
         if (busy) bcyc++;
      end while (!done && cyc < 300);
      checks++;
      if (cyc !== elat) begin
         failures++;
         $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, elat);
      end
      checks++;
      if (M !== em) begin
         failures++;
         $display("FAIL %s M: got %0d, expected %0d", name, M, em);
      end
      checks++;
      if (err !== ee) begin
         failures++;
         $display("FAIL %s err: got %b, expected %b", name, err, ee);
      end
      checks++;
      if (bcyc !== elat - 1) begin
         failures++;
         $display("FAIL %s busy_cycles: got %0d, expected %0d", name, bcyc, elat - 1);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL %s done_pulse: done still %b one cycle later, expected 0", name, done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({M, busy, done, err} !== '0) begin
         failures++;
         $display("FAIL reset_state: M=%0d busy=%b done=%b err=%b, expected all 0", M, busy, done, err);
      end
      rst = 1'b1;
      // start on the very first edge after release
      run_decode(8'd31, 8'd7, 8'd33, 8'd4, 1'b0, 137, "first_after_reset");
   endtask

   task automatic test_vectors();
      run_decode(8'd11,  8'd23, 8'd187, 8'd88,  1'b0, 137, "n187_d23");
      run_decode(8'd88,  8'd7,  8'd187, 8'd11,  1'b0, 137, "encode_88_e7");
      run_decode(8'd11,  8'd23, 8'd187, 8'd88,  1'b0, 137, "roundtrip_decode");
      run_decode(8'd64,  8'd7,  8'd33,  8'd4,   1'b0, 137, "c_ge_n");
      run_decode(8'd64,  8'd0,  8'd33,  8'd1,   1'b0, 137, "d_zero");
      run_decode(8'd2,   8'd10, 8'd255, 8'd4,   1'b0, 137, "n255_pow2");
      run_decode(8'd3,   8'd5,  8'd254, 8'd243, 1'b0, 137, "n254_pow3");
      run_decode(8'd255, 8'd1,  8'd254, 8'd1,   1'b0, 137, "c_max_reduce");
      run_decode(8'd200, 8'd1,  8'd255, 8'd200, 1'b0, 137, "d_one");
      run_decode(8'd3,   8'd3,  8'd2,   8'd1,   1'b0, 137, "n_two");
   endtask

   task automatic test_error();
      run_decode(8'd5,  8'd3, 8'd1, 8'd0, 1'b1, 1, "n_one_err");
      run_decode(8'd9,  8'd2, 8'd0, 8'd0, 1'b1, 1, "n_zero_err");
      run_decode(8'd31, 8'd7, 8'd33, 8'd4, 1'b0, 137, "err_cleared");
   endtask

   task automatic test_abort();
      int dcnt = 0;
      start = 1'b1; C = 8'd31; D = 8'd7; N = 8'd33;
      @(posedge clk);
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
      end
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL abort_busy_before: got %b, expected 1", busy);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({M, busy, done, err} !== '0) begin
         failures++;
         $display("FAIL abort_outputs: M=%0d busy=%b done=%b err=%b, expected all 0", M, busy, done, err);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      checks++;
      if (dcnt !== 0) begin
         failures++;
         $display("FAIL abort_no_done: got %0d done cycles, expected 0", dcnt);
      end
      run_decode(8'd31, 8'd7, 8'd33, 8'd4, 1'b0, 137, "after_abort");
   endtask

   task automatic test_restart_ignored();
      int cyc = 0;
      start = 1'b1; C = 8'd31; D = 8'd7; N = 8'd33;
      @(posedge clk);
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) start = 1'b0;
         if (cyc == 20) begin
            start = 1'b1; C = 8'd5; D = 8'd3; N = 8'd7;
         end
         if (cyc == 21) start = 1'b0;
      end while (!done && cyc < 300);
      checks++;
      if (cyc !== 137) begin
         failures++;
         $display("FAIL restart_latency: got %0d cycles, expected 137", cyc);
      end
      checks++;
      if (M !== 8'd4) begin
         failures++;
         $display("FAIL restart_M: got %0d, expected 4", M);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int cyc = 0;
      int cyc2 = 0;
      logic idle_busy = 1'b1;
      start = 1'b1; C = 8'd31; D = 8'd7; N = 8'd33;
      @(posedge clk);
      do begin
         @(negedge clk);
         cyc++;
      end while (!done && cyc < 300);
      checks++;
      if (cyc !== 137 || M !== 8'd4) begin
         failures++;
         $display("FAIL b2b_first: got %0d cycles M=%0d, expected 137 cycles M=4", cyc, M);
      end
      C = 8'd3; D = 8'd5; N = 8'd254;
      do begin
         @(negedge clk);
         cyc2++;
         if (cyc2 == 1) idle_busy = busy;
         if (cyc2 == 2) start = 1'b0;
      end while (!done && cyc2 < 300);
      checks++;
      if (idle_busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle_gap: busy=%b in the cycle after done, expected 0", idle_busy);
      end
      checks++;
      if (cyc2 !== 138) begin
         failures++;
         $display("FAIL b2b_second_latency: got %0d cycles after first done, expected 138", cyc2);
      end
      checks++;
      if (M !== 8'd243) begin
         failures++;
         $display("FAIL b2b_second_M: got %0d, expected 243", M);
      end
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_vectors();
      test_error();
      test_abort();
      test_restart_ignored();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rsa_decoder.md
RSA_DECODER -- requirements
Module: rsa_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width of C, D, N and M.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to start a decode, sampled on the rising edge.
REQ-005 The block SHALL have port C, input, WIDTH bits: the ciphertext.
REQ-006 The block SHALL have port D, input, WIDTH bits: the private exponent.
REQ-007 The block SHALL have port N, input, WIDTH bits: the modulus.
REQ-008 The block SHALL have port M, output, WIDTH bits: the recovered plaintext, registered.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a decode is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse when M is valid.
REQ-011 The block SHALL have port err, output, 1 bit: set when N < 2, valid while done is high.

Function
REQ-012 The block SHALL compute M = C^D mod N.
REQ-013 The block SHALL have the states IDLE, REDUCE, SQUARE, MULT and DONE.
REQ-014 In IDLE, start=1 SHALL latch C, D and N internally, set busy=1 and move to REDUCE; later changes on C, D and N SHALL have no effect.
REQ-015 If N < 2 when start is sampled, the FSM SHALL go directly to DONE, with M=0 and err=1.
REQ-016 REDUCE SHALL set the base b = C mod N in 8 cycles, using the modular multiplier with operands (1, C).
REQ-017 After REDUCE, the accumulator r SHALL be set to 1 mod N.
REQ-018 The exponent SHALL be scanned MSB-first over bits i = WIDTH-1 down to 0, with two steps per bit:
- SQUARE: r = r*r mod N.
- MULT: t = r*b mod N, then r = t only if D[i]=1.
REQ-019 MULT SHALL always execute, so that latency is independent of D (constant-time).
REQ-020 Each modular multiply SHALL take exactly WIDTH cycles: interleaved shift-add, MSB-first over the second operand.
- Per step: acc = 2*acc mod N, then acc = acc + a mod N if the operand bit is set.
- Intermediate values SHALL be held at WIDTH+1 bits, and each reduction SHALL be a single conditional subtract of N.
REQ-021 Total latency SHALL be fixed at 8 + 16*8 = 136 busy cycles.
- done SHALL be high in the cycle after the last MULT step completes, i.e. the 137th cycle after the start-sampling edge.
REQ-022 In DONE, M SHALL be updated, done=1 and busy=0 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-023 start while busy=1 SHALL be ignored, with no restart and no queuing.
REQ-024 start held high SHALL begin a new decode in the cycle after DONE returns to IDLE.
REQ-025 M SHALL hold its last value until the next DONE; err SHALL be cleared on the next accepted start.
REQ-026 For D=0, the result SHALL be M=1 for N >= 2.
REQ-027 For C >= N, the ciphertext SHALL be reduced correctly by REDUCE.

Reset
REQ-028 rst=0 SHALL asynchronously force the FSM to IDLE and set M=0, busy=0, done=0 and err=0, together with all internal registers.
REQ-029 Reset asserted mid-operation SHALL abort the decode, and done SHALL NOT be asserted for the aborted operation.
REQ-030 After rst releases, the block SHALL accept start on the first rising edge.

Structure
REQ-031 A shared package rsa_pkg SHALL hold the WIDTH constant and the FSM state encoding, so that the encoder and decoder share them.
REQ-032 The single sub-module SHALL be rsa_modmul, a sequential (a*b) mod n unit with a start/done handshake and WIDTH-cycle latency, reused for REDUCE, SQUARE and MULT.

Verification
REQ-033 Scenario N=33, D=7, C=31, start pulse: done SHALL pulse once, 137 cycles after start, with M=4 and err=0.
REQ-034 Scenario N=187, D=23, C=11: the result SHALL be M=88; encoding 88 with e=7 and decoding it SHALL round-trip.
REQ-035 Scenario N=33, D=7, C=64 (C >= N): the result SHALL be M=4; with D=0, the result SHALL be M=1.
REQ-036 Scenario N=1 with start: done SHALL be high on the next cycle with err=1 and M=0.
REQ-037 Scenario reset asserted at cycle 50 of a decode: outputs SHALL go to 0 immediately and no done pulse SHALL occur. A following decode with N=33, D=7, C=31 SHALL give M=4.
REQ-038 Scenario start re-pulsed at cycle 20 with different C: it SHALL be ignored, the result SHALL equal that of the original operands, and latency SHALL be unchanged.
